// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the BCD stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {SW_IDLE, SW_RUN, SW_PAUSE} sw_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_NINE = 4'd9;
  localparam bcd_t BCD_FIVE = 4'd5;

endpackage

// File: rtl/bcd_digit_ctr.sv
// Single BCD digit counting 0..MAX on inc, rolling to 0 with a carry out.
module bcd_digit_ctr
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic carry
);

  localparam bcd_t MaxDigit = bcd_t'(MAX);

  bcd_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = (q_q == MaxDigit) ? '0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = inc & (q_q == MaxDigit);

endmodule

// File: rtl/stopwatch_bcd.sv
// BCD mm:ss.mmm stopwatch counting rising edges of a 1 ms square wave.
// Optional lap freeze of the displayed value when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int unsigned MIN_MAX = 59,
  parameter bit          WRAP    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_in,
  input  logic        start_stop,
  input  logic        clear,
`ifdef STOPWATCH_LAP_EN
  input  logic        lap,
  output logic        lap_active,
`endif
  output logic        div_clr,
  output logic        running,
  output logic [11:0] ms_bcd,
  output logic [7:0]  sec_bcd,
  output logic [7:0]  min_bcd,
  output logic        ovf
);

  localparam bcd_t MinTens  = bcd_t'(MIN_MAX / 10);
  localparam bcd_t MinUnits = bcd_t'(MIN_MAX % 10);

  sw_state_t state_q, state_d;
  logic      tick_prev_q;
  logic      ovf_q, ovf_d;

  logic tick_rise, cnt_en, at_term, min_at_max, wrap_evt;
  logic inc_ms0, inc_min0, clr_min;
  logic c_ms0, c_ms1, c_ms2, c_sec0, c_sec1, c_min0, min1_carry_unused;
  bcd_t ms0, ms1, ms2, sec0, sec1, min0, min1;
  logic [27:0] live, disp;

  assign tick_rise  = tick_in & ~tick_prev_q;
  assign cnt_en     = (state_q == SW_RUN) & tick_rise & ~clear;
  assign min_at_max = (min1 == MinTens) & (min0 == MinUnits);
  assign at_term    = min_at_max & (sec1 == BCD_FIVE) & (sec0 == BCD_NINE) &
                      (ms2 == BCD_NINE) & (ms1 == BCD_NINE) & (ms0 == BCD_NINE);

  // Saturating build stops the whole chain at the terminal value.
  assign inc_ms0  = cnt_en & (WRAP | ~at_term);
  assign wrap_evt = c_sec1 & min_at_max;
  assign inc_min0 = c_sec1 & ~min_at_max;
  assign clr_min  = clear | wrap_evt;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = SW_IDLE;
    end else if (start_stop) begin
      case (state_q)
        SW_IDLE:  state_d = SW_RUN;
        SW_RUN:   state_d = SW_PAUSE;
        SW_PAUSE: state_d = SW_RUN;
        default:  state_d = SW_IDLE;
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (clear) begin
      ovf_d = 1'b0;
    end else if (WRAP) begin
      ovf_d = wrap_evt;
    end else if (cnt_en & at_term) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SW_IDLE;
      tick_prev_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_prev_q <= tick_in;
      ovf_q       <= ovf_d;
    end
  end

  bcd_digit_ctr #(.MAX(9)) u_ms0 (
    .clk(clk), .rst(rst), .clr(clear), .inc(inc_ms0), .q(ms0), .carry(c_ms0)
  );
  bcd_digit_ctr #(.MAX(9)) u_ms1 (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_ms0), .q(ms1), .carry(c_ms1)
  );
  bcd_digit_ctr #(.MAX(9)) u_ms2 (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_ms1), .q(ms2), .carry(c_ms2)
  );
  bcd_digit_ctr #(.MAX(9)) u_sec0 (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_ms2), .q(sec0), .carry(c_sec0)
  );
  bcd_digit_ctr #(.MAX(5)) u_sec1 (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_sec0), .q(sec1), .carry(c_sec1)
  );
  // Minutes never pass MIN_MAX: increment is gated and wrap clears both digits.
  bcd_digit_ctr #(.MAX(9)) u_min0 (
    .clk(clk), .rst(rst), .clr(clr_min), .inc(inc_min0), .q(min0), .carry(c_min0)
  );
  bcd_digit_ctr #(.MAX(9)) u_min1 (
    .clk(clk), .rst(rst), .clr(clr_min), .inc(c_min0), .q(min1), .carry(min1_carry_unused)
  );

  assign live = {min1, min0, sec1, sec0, ms2, ms1, ms0};

`ifdef STOPWATCH_LAP_EN
  logic        lap_q, lap_d;
  logic [27:0] frz_q, frz_d;

  always_comb begin
    lap_d = lap_q;
    frz_d = frz_q;
    if (clear) begin
      lap_d = 1'b0;
    end else if (state_q == SW_RUN) begin
      if (start_stop) begin
        lap_d = 1'b0;
      end else if (lap) begin
        lap_d = ~lap_q;
        if (!lap_q) frz_d = live;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_q <= 1'b0;
      frz_q <= '0;
    end else begin
      lap_q <= lap_d;
      frz_q <= frz_d;
    end
  end

  assign disp       = lap_q ? frz_q : live;
  assign lap_active = lap_q;
`else
  assign disp = live;
`endif

  assign min_bcd = disp[27:20];
  assign sec_bcd = disp[19:12];
  assign ms_bcd  = disp[11:0];
  assign div_clr = (state_q != SW_RUN);
  assign running = (state_q == SW_RUN);
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: three instances (59/saturate, 1/saturate, 1/wrap) on shared stimulus.
module tb_stopwatch_bcd;

  logic clk = 1'b0;
  logic rst, tick_in, start_stop, clear, lap;

  always #5 clk = ~clk;

  logic        run_w [3];
  logic        dclr_w[3];
  logic        ovf_w [3];
  logic        lap_w [3];
  logic [11:0] ms_w  [3];
  logic [7:0]  sec_w [3];
  logic [7:0]  min_w [3];

  stopwatch_bcd #(.MIN_MAX(59), .WRAP(1'b0)) dut_a (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
    .lap(lap), .lap_active(lap_w[0]),
`endif
    .div_clr(dclr_w[0]), .running(run_w[0]), .ms_bcd(ms_w[0]), .sec_bcd(sec_w[0]),
    .min_bcd(min_w[0]), .ovf(ovf_w[0])
  );
  stopwatch_bcd #(.MIN_MAX(1), .WRAP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
    .lap(lap), .lap_active(lap_w[1]),
`endif
    .div_clr(dclr_w[1]), .running(run_w[1]), .ms_bcd(ms_w[1]), .sec_bcd(sec_w[1]),
    .min_bcd(min_w[1]), .ovf(ovf_w[1])
  );
  stopwatch_bcd #(.MIN_MAX(1), .WRAP(1'b1)) dut_c (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
    .lap(lap), .lap_active(lap_w[2]),
`endif
    .div_clr(dclr_w[2]), .running(run_w[2]), .ms_bcd(ms_w[2]), .sec_bcd(sec_w[2]),
    .min_bcd(min_w[2]), .ovf(ovf_w[2])
  );

`ifndef STOPWATCH_LAP_EN
  assign lap_w[0] = 1'b0;
  assign lap_w[1] = 1'b0;
  assign lap_w[2] = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: elapsed time as a plain millisecond count per instance.
  int mtot  [3];
  int mstate[3];  // 0 idle, 1 run, 2 pause
  int mfrz  [3];
  bit movf  [3];
  bit mlap  [3];
  bit mprev;

  function automatic int term_of(int i);
    return (((i == 0) ? 59 : 1) * 60 + 59) * 1000 + 999;
  endfunction

  function automatic bit wrap_of(int i);
    return (i == 2);
  endfunction

  function automatic logic [7:0] bcd2(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [11:0] bcd3(int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // {lap_active, running, div_clr, ovf, min, sec, ms}
  function automatic logic [31:0] mkv(logic run, logic dclr, logic ov, logic [7:0] mn,
                                      logic [7:0] sc, logic [11:0] ms);
    return {1'b0, run, dclr, ov, mn, sc, ms};
  endfunction

  function automatic logic [31:0] act_vec(int i);
    return {lap_w[i], run_w[i], dclr_w[i], ovf_w[i], min_w[i], sec_w[i], ms_w[i]};
  endfunction

  function automatic logic [31:0] exp_vec(int i);
    int d;
    d = mlap[i] ? mfrz[i] : mtot[i];
    return {mlap[i], mstate[i] == 1, mstate[i] != 1, movf[i],
            bcd2(d / 60000), bcd2((d / 1000) % 60), bcd3(d % 1000)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mtot[i] = 0; mstate[i] = 0; mfrz[i] = 0; movf[i] = 1'b0; mlap[i] = 1'b0;
    end
    mprev = 1'b0;
  endtask

  task automatic model_update();
    bit hit;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      hit = 1'b0;
      if (clear) begin
        mtot[i] = 0; mstate[i] = 0; movf[i] = 1'b0; mlap[i] = 1'b0;
      end else begin
        if (mstate[i] == 1) begin
          if (start_stop) mlap[i] = 1'b0;
          else if (lap) begin
            if (!mlap[i]) mfrz[i] = mtot[i];
            mlap[i] = !mlap[i];
          end
        end
        if (mstate[i] == 1 && tick_in && !mprev) begin
          if (mtot[i] == term_of(i)) begin
            hit = 1'b1;
            if (wrap_of(i)) mtot[i] = 0;
          end else begin
            mtot[i]++;
          end
        end
        movf[i] = wrap_of(i) ? hit : (movf[i] | hit);
        if (start_stop) mstate[i] = (mstate[i] == 1) ? 2 : 1;
      end
    end
    mprev = tick_in;
  endtask

  // One clock: model follows the edge, all instances compared at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("model[%0d]", i), act_vec(i), exp_vec(i));
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      tick_in = 1'b1;
      cycle();
      tick_in = 1'b0;
      cycle();
    end
  endtask

  // Fast-forward ss.mmm from 00.000 to 59.999 by forcing the digit increments.
  task automatic preload_lower();
    force dut_a.u_ms0.inc = 1'b1; force dut_a.u_ms1.inc = 1'b1; force dut_a.u_ms2.inc = 1'b1;
    force dut_a.u_sec0.inc = 1'b1; force dut_a.u_sec1.inc = 1'b1;
    force dut_b.u_ms0.inc = 1'b1; force dut_b.u_ms1.inc = 1'b1; force dut_b.u_ms2.inc = 1'b1;
    force dut_b.u_sec0.inc = 1'b1; force dut_b.u_sec1.inc = 1'b1;
    force dut_c.u_ms0.inc = 1'b1; force dut_c.u_ms1.inc = 1'b1; force dut_c.u_ms2.inc = 1'b1;
    force dut_c.u_sec0.inc = 1'b1; force dut_c.u_sec1.inc = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    release dut_a.u_sec1.inc; release dut_b.u_sec1.inc; release dut_c.u_sec1.inc;
    repeat (4) @(posedge clk);
    @(negedge clk);
    release dut_a.u_ms0.inc; release dut_a.u_ms1.inc; release dut_a.u_ms2.inc;
    release dut_a.u_sec0.inc;
    release dut_b.u_ms0.inc; release dut_b.u_ms1.inc; release dut_b.u_ms2.inc;
    release dut_b.u_sec0.inc;
    release dut_c.u_ms0.inc; release dut_c.u_ms1.inc; release dut_c.u_ms2.inc;
    release dut_c.u_sec0.inc;
    for (int i = 0; i < 3; i++) mtot[i] += 59999;
  endtask

  typedef struct packed {
    logic        ss;
    logic        clr;
    logic        tk;
    logic [31:0] expv;
  } row_t;

  row_t tbl[16];

  initial begin
    // Directed single-cycle vectors for dut_a, starting from IDLE with tick low.
    tbl[0]  = {1'b0, 1'b0, 1'b1, mkv(0, 1, 0, 8'h00, 8'h00, 12'h000)};
    tbl[1]  = {1'b0, 1'b0, 1'b0, mkv(0, 1, 0, 8'h00, 8'h00, 12'h000)};
    tbl[2]  = {1'b1, 1'b0, 1'b0, mkv(1, 0, 0, 8'h00, 8'h00, 12'h000)};
    tbl[3]  = {1'b0, 1'b0, 1'b1, mkv(1, 0, 0, 8'h00, 8'h00, 12'h001)};
    tbl[4]  = {1'b0, 1'b0, 1'b1, mkv(1, 0, 0, 8'h00, 8'h00, 12'h001)};
    tbl[5]  = {1'b0, 1'b0, 1'b0, mkv(1, 0, 0, 8'h00, 8'h00, 12'h001)};
    tbl[6]  = {1'b1, 1'b0, 1'b1, mkv(0, 1, 0, 8'h00, 8'h00, 12'h002)};
    tbl[7]  = {1'b0, 1'b0, 1'b0, mkv(0, 1, 0, 8'h00, 8'h00, 12'h002)};
    tbl[8]  = {1'b1, 1'b0, 1'b1, mkv(1, 0, 0, 8'h00, 8'h00, 12'h002)};
    tbl[9]  = {1'b0, 1'b0, 1'b0, mkv(1, 0, 0, 8'h00, 8'h00, 12'h002)};
    tbl[10] = {1'b1, 1'b1, 1'b1, mkv(0, 1, 0, 8'h00, 8'h00, 12'h000)};
    tbl[11] = {1'b1, 1'b0, 1'b0, mkv(1, 0, 0, 8'h00, 8'h00, 12'h000)};
    tbl[12] = {1'b0, 1'b0, 1'b1, mkv(1, 0, 0, 8'h00, 8'h00, 12'h001)};
    tbl[13] = {1'b0, 1'b0, 1'b0, mkv(1, 0, 0, 8'h00, 8'h00, 12'h001)};
    tbl[14] = {1'b0, 1'b1, 1'b0, mkv(0, 1, 0, 8'h00, 8'h00, 12'h000)};
    tbl[15] = {1'b0, 1'b0, 1'b1, mkv(0, 1, 0, 8'h00, 8'h00, 12'h000)};

    rst = 1'b1; tick_in = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    model_reset();
    repeat (2) cycle();
    for (int i = 0; i < 3; i++)
      check($sformatf("reset[%0d]", i), act_vec(i), mkv(0, 1, 0, 8'h00, 8'h00, 12'h000));
    rst = 1'b0;
    cycle();

    for (int k = 0; k < 16; k++) begin
      start_stop = tbl[k].ss; clear = tbl[k].clr; tick_in = tbl[k].tk;
      cycle();
      check($sformatf("table[%0d]", k), act_vec(0), tbl[k].expv);
    end
    start_stop = 1'b0; clear = 1'b0; tick_in = 1'b0;
    cycle();

    // One second of ticks.
    start_stop = 1'b1; cycle(); start_stop = 1'b0;
    tick_n(1000);
    check("one_second", act_vec(0), mkv(1, 0, 0, 8'h00, 8'h01, 12'h000));

    // Run on to 12.345, then asynchronous reset between clock edges.
    tick_n(11345);
    check("at_12_345", act_vec(0), mkv(1, 0, 0, 8'h00, 8'h12, 12'h345));
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("async_rst[%0d]", i), act_vec(i), mkv(0, 1, 0, 8'h00, 8'h00, 12'h000));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // Minute carry from 00:59.999.
    preload_lower();
    check("preload_59_999", act_vec(0), mkv(0, 1, 0, 8'h00, 8'h59, 12'h999));
    start_stop = 1'b1; cycle(); start_stop = 1'b0;
    tick_in = 1'b1; cycle();
    check("minute_carry", act_vec(0), mkv(1, 0, 0, 8'h01, 8'h00, 12'h000));
    tick_in = 1'b0; cycle();

    // Terminal value 01:59.999 on the MIN_MAX=1 instances.
    start_stop = 1'b1; cycle(); start_stop = 1'b0;
    preload_lower();
    start_stop = 1'b1; cycle(); start_stop = 1'b0;
    tick_in = 1'b1; cycle();
    check("term_a_counts", act_vec(0), mkv(1, 0, 0, 8'h02, 8'h00, 12'h000));
    check("term_b_sat",    act_vec(1), mkv(1, 0, 1, 8'h01, 8'h59, 12'h999));
    check("term_c_wrap",   act_vec(2), mkv(1, 0, 1, 8'h00, 8'h00, 12'h000));
    tick_in = 1'b0; cycle();
    check("wrap_ovf_pulse", act_vec(2), mkv(1, 0, 0, 8'h00, 8'h00, 12'h000));
    tick_n(3);
    check("sat_sticky", act_vec(1), mkv(1, 0, 1, 8'h01, 8'h59, 12'h999));

    // Random control traffic, everything checked against the model each cycle.
    for (int k = 0; k < 4000; k++) begin
      tick_in    = 1'($urandom_range(0, 1));
      start_stop = ($urandom_range(0, 15) == 0);
      clear      = ($urandom_range(0, 499) == 0);
`ifdef STOPWATCH_LAP_EN
      lap        = ($urandom_range(0, 31) == 0);
`endif
      cycle();
    end
    tick_in = 1'b0; start_stop = 1'b0; lap = 1'b0;
    clear = 1'b1; cycle(); clear = 1'b0;
    for (int i = 0; i < 3; i++)
      check($sformatf("clear[%0d]", i), act_vec(i), mkv(0, 1, 0, 8'h00, 8'h00, 12'h000));
    cycle();

`ifdef STOPWATCH_LAP_EN
    start_stop = 1'b1; cycle(); start_stop = 1'b0;
    tick_n(2500);
    lap = 1'b1; cycle(); lap = 1'b0;
    check("lap_freeze", act_vec(0), {1'b1, mkv(1, 0, 0, 8'h00, 8'h02, 12'h500)} & 32'hFFFF_FFFF
          | 32'h8000_0000);
    tick_n(500);
    check("lap_held", act_vec(0), mkv(1, 0, 0, 8'h00, 8'h02, 12'h500) | 32'h8000_0000);
    lap = 1'b1; cycle(); lap = 1'b0;
    check("lap_release", act_vec(0), mkv(1, 0, 0, 8'h00, 8'h03, 12'h000));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
